mcc_serial_subtractor: RTL

MCC_SERIAL_SUBTRACTOR -- requirements
Module: mcc_serial_subtractor

---
 rtl/mcc_serial_subtractor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mcc_serial_subtractor.sv
// rtl/mcc_serial_subtractor.sv - bit-serial a - b (a + ~b + 1), LSB first, one bit per clock
module mcc_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             nb;
    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] res_full;

    // Full-adder slice on a + ~b; the carry register supplies the +1.
    assign nb       = ~b_sh_q[0];
    assign s        = a_sh_q[0] ^ nb ^ c_q;
    assign c_next   = (a_sh_q[0] & nb) | (c_q & (a_sh_q[0] ^ nb));
    assign res_full = {s, res_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    c_d      = 1'b1;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                end
            end
            S_RUN: begin
                res_sh_d = res_full;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                c_d      = c_next;
                cnt_d    = cnt_q + CW'(1);
                // Last bit: publish all results together on the done edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    diff_d   = res_full;
                    borrow_d = ~c_next;
                    zero_d   = (res_full == '0);
                    ovf_d    = (a_msb_q != b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b1;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule
